// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline with Decode-stage branches.
// All control outputs are combinational; only the stall-cycle counter is registered.
module hazard_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BranchD,
  input  logic             jump,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic [4:0]       WriteRegM,
  input  logic             MemtoRegM,
  input  logic             RegWriteM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt
);

  logic w_lwstall;
  logic w_branchstall;
  logic w_stall;
  logic w_br_e;
  logic w_br_m;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    ForwardAE = 2'b00;
    if ((RsE != 5'd0) && (RsE == WriteRegM) && RegWriteM)
      ForwardAE = 2'b10;
    else if ((RsE != 5'd0) && (RsE == WriteRegW) && RegWriteW)
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if ((RtE != 5'd0) && (RtE == WriteRegM) && RegWriteM)
      ForwardBE = 2'b10;
    else if ((RtE != 5'd0) && (RtE == WriteRegW) && RegWriteW)
      ForwardBE = 2'b01;
  end

  assign ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;

  // Load-use check deliberately compares against register 0 too.
  assign w_lwstall     = MemtoRegE && ((RsD == RtE) || (RtD == RtE));
  assign w_br_e        = RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign w_br_m        = MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD));
  assign w_branchstall = BranchD && (w_br_e || w_br_m);
  assign w_stall       = (w_lwstall || w_branchstall) && !jump;

  assign StallF = w_stall;
  assign StallD = w_stall;
  assign FlushE = w_stall;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_stall && (r_cnt != '1))
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a second narrow-counter instance exercises saturation.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        BranchD, jump;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cnt;
  logic        s_StallF, s_StallD, s_FlushE, s_ForwardAD, s_ForwardBD;
  logic [1:0]  s_ForwardAE, s_ForwardBE;
  logic [1:0]  s_stall_cnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .BranchD(BranchD), .jump(jump),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .stall_cnt(stall_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .BranchD(BranchD), .jump(jump),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE),
    .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .stall_cnt(s_stall_cnt)
  );

  task automatic clear_inputs();
    BranchD = 0; jump = 0;
    RsD = 5'd1; RtD = 5'd2; RsE = 5'd3; RtE = 5'd4;
    WriteRegE = 5'd5; WriteRegM = 5'd6; WriteRegW = 5'd7;
    MemtoRegE = 0; RegWriteE = 0; MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    else pass_cnt++;
    total++;
    if (s_stall_cnt !== 2'd0) $display("FAIL reset_cnt_small got=%0d exp=0", s_stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL nohaz_stall got=%b exp=000", {StallF, StallD, FlushE});
    else pass_cnt++;
    total++;
    if ({ForwardAD, ForwardBD, ForwardAE, ForwardBE} !== 6'b000000)
      $display("FAIL nohaz_fwd got=%b exp=000000", {ForwardAD, ForwardBD, ForwardAE, ForwardBE});
    else pass_cnt++;
  endtask

  task automatic test_fwd_execute();
    clear_inputs();
    RsE = 5'd5; RtE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1; WriteRegW = 5'd5; RegWriteW = 1;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) $display("FAIL fwdE_mem_prio got=%b exp=1010", {ForwardAE, ForwardBE});
    else pass_cnt++;
    RegWriteM = 0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0101) $display("FAIL fwdE_wb got=%b exp=0101", {ForwardAE, ForwardBE});
    else pass_cnt++;
    RsE = 5'd0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) $display("FAIL fwdE_r0 got=%b exp=0001", {ForwardAE, ForwardBE});
    else pass_cnt++;
    RegWriteW = 0; RegWriteM = 1; RtE = 5'd0; WriteRegM = 5'd0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) $display("FAIL fwdE_r0_mem got=%b exp=0000", {ForwardAE, ForwardBE});
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemtoRegE = 1; RtE = 5'd8; RsD = 5'd8;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lw_rs got=%b exp=111", {StallF, StallD, FlushE});
    else pass_cnt++;
    jump = 1;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL lw_jump got=%b exp=000", {StallF, StallD, FlushE});
    else pass_cnt++;
    jump = 0; RsD = 5'd1; RtD = 5'd8;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lw_rt got=%b exp=111", {StallF, StallD, FlushE});
    else pass_cnt++;
    MemtoRegE = 0;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL lw_noload got=%b exp=000", {StallF, StallD, FlushE});
    else pass_cnt++;
    MemtoRegE = 1; RtE = 5'd0; RsD = 5'd0; RtD = 5'd2;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lw_r0 got=%b exp=111", {StallF, StallD, FlushE});
    else pass_cnt++;
  endtask

  task automatic test_branch_execute();
    clear_inputs();
    BranchD = 1; RegWriteE = 1; WriteRegE = 5'd3; RtD = 5'd3;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL brE_stall got=%b exp=111", {StallF, StallD, FlushE});
    else pass_cnt++;
    BranchD = 0;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL brE_nobranch got=%b exp=000", {StallF, StallD, FlushE});
    else pass_cnt++;
    BranchD = 1; RegWriteE = 0;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL brE_nowrite got=%b exp=000", {StallF, StallD, FlushE});
    else pass_cnt++;
  endtask

  task automatic test_branch_memory();
    clear_inputs();
    BranchD = 1; MemtoRegM = 1; WriteRegM = 5'd4; RsD = 5'd4; RtD = 5'd9;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL brM_stall got=%b exp=111", {StallF, StallD, FlushE});
    else pass_cnt++;
    total++;
    if (ForwardAD !== 1'b0) $display("FAIL brM_ad_noreg got=%b exp=0", ForwardAD);
    else pass_cnt++;
    MemtoRegM = 0; RegWriteM = 1;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL brM_nostall got=%b exp=000", {StallF, StallD, FlushE});
    else pass_cnt++;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b10) $display("FAIL brM_fwdAD got=%b exp=10", {ForwardAD, ForwardBD});
    else pass_cnt++;
    RsD = 5'd9; RtD = 5'd4;
    #1;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b01) $display("FAIL brM_fwdBD got=%b exp=01", {ForwardAD, ForwardBD});
    else pass_cnt++;
    RsD = 5'd0; WriteRegM = 5'd0;
    #1;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b00) $display("FAIL brM_r0 got=%b exp=00", {ForwardAD, ForwardBD});
    else pass_cnt++;
  endtask

  task automatic test_counter();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL cnt_reset got=%0d exp=0", stall_cnt);
    else pass_cnt++;
    @(negedge clk);
    reset = 0;
    MemtoRegE = 1; RtE = 5'd8; RsD = 5'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (stall_cnt !== 32'd3) $display("FAIL cnt_three got=%0d exp=3", stall_cnt);
    else pass_cnt++;
    total++;
    if (s_stall_cnt !== 2'd3) $display("FAIL cnt_small_three got=%0d exp=3", s_stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    MemtoRegE = 1; RtE = 5'd8; RsD = 5'd8;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (stall_cnt !== 32'd5) $display("FAIL cnt_five got=%0d exp=5", stall_cnt);
    else pass_cnt++;
    total++;
    if (s_stall_cnt !== 2'd3) $display("FAIL cnt_saturate got=%0d exp=3", s_stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_clears();
    @(negedge clk);
    reset = 1;
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL reset_comb got=%b exp=111", {StallF, StallD, FlushE});
    else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (stall_cnt !== 32'd0 || s_stall_cnt !== 2'd0)
      $display("FAIL cnt_rereset got=%0d/%0d exp=0/0", stall_cnt, s_stall_cnt);
    else pass_cnt++;
    @(negedge clk);
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_fwd_execute();
    test_load_use();
    test_branch_execute();
    test_branch_memory();
    test_counter();
    test_saturation();
    test_reset_clears();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
